// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: direction encoding, default
// parameter values and a helper that sizes the prescaler register.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_MAX_VAL  = 255;
    localparam int DEFAULT_PRESCALE = 1;

    // A prescale of 1 still needs a 1-bit register so the port list stays legal.
    function automatic int prescale_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable-gated prescaler: counts 0..PRESCALE-1 on enabled cycles and raises
// tick combinationally on the enabled cycle that completes a full period.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              PW   = prescale_width(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = en & ~clr & (cnt_q == LAST);

    // NOTE: state registers use <= and reset asynchronously; only the flop is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Prescaled modulo-(MAX_VAL+1) up/down counter with terminal-count pulse and
// sticky wrap flag. Define COUNTER_CMP_EN to add the cmp_val/match compare.
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MAX_VAL  = DEFAULT_MAX_VAL,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             ovf_clr,
`ifdef COUNTER_CMP_EN
    input  logic [WIDTH-1:0] cmp_val,
    output logic             match,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q;
    logic             ovf_q, ovf_d;
    logic             step;
    logic             wrap;
    logic             presc_clr;

    // Load restarts the prescale period exactly like clear does.
    assign presc_clr = clr | load;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (presc_clr),
        .tick (step)
    );

    always_comb begin
        count_d = count_q;
        wrap    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MAX_W) ? MAX_W : load_val;
        end else if (step) begin
            if (up == DIR_UP) begin
                if (count_q == MAX_W) begin
                    count_d = '0;
                    wrap    = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_W;
                    wrap    = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
        // A wrap in the same cycle as ovf_clr wins, so no wrap is ever lost.
        ovf_d = wrap | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= wrap;
            ovf_q   <= ovf_d;
        end
    end

`ifdef COUNTER_CMP_EN
    logic match_q;

    // Compare against the next count so match lines up with count on the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= (count_d == cmp_val);
        end
    end

    assign match = match_q;
`endif

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: two instances (PRESCALE 1 and 3, MAX_VAL 9) share
// one stimulus stream and are checked against an arithmetic reference model.
module tb_updown_counter;

    localparam int W    = 4;
    localparam int MAXV = 9;

    logic         clk = 1'b0;
    logic         rst, en, clr, load, up, ovf_clr;
    logic [W-1:0] load_val, cmp_val;
    logic [W-1:0] count_a, count_b;
    logic         tc_a, tc_b, ovf_a, ovf_b;
`ifdef COUNTER_CMP_EN
    logic         match_a, match_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = instance A, 1 = instance B.
    int presc   [2] = '{1, 3};
    int m_count [2];
    int m_encnt [2];
    bit m_tc    [2];
    bit m_ovf   [2];
    bit m_match [2];

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(W), .MAX_VAL(MAXV), .PRESCALE(1)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .up       (up),
        .ovf_clr  (ovf_clr),
`ifdef COUNTER_CMP_EN
        .cmp_val  (cmp_val),
        .match    (match_a),
`endif
        .count    (count_a),
        .tc       (tc_a),
        .ovf      (ovf_a)
    );

    updown_counter #(.WIDTH(W), .MAX_VAL(MAXV), .PRESCALE(3)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .up       (up),
        .ovf_clr  (ovf_clr),
`ifdef COUNTER_CMP_EN
        .cmp_val  (cmp_val),
        .match    (match_b),
`endif
        .count    (count_b),
        .tc       (tc_b),
        .ovf      (ovf_b)
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_count[i] = 0;
            m_encnt[i] = 0;
            m_tc[i]    = 1'b0;
            m_ovf[i]   = 1'b0;
            m_match[i] = 1'b0;
        end
    endtask

    // Steps happen every presc[i]-th enabled cycle; count lives in 0..MAXV.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit wrap;
            wrap = 1'b0;
            if (clr) begin
                m_count[i] = 0;
                m_encnt[i] = 0;
            end else if (load) begin
                m_count[i] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
                m_encnt[i] = 0;
            end else if (en) begin
                m_encnt[i]++;
                if (m_encnt[i] == presc[i]) begin
                    m_encnt[i] = 0;
                    if (up) begin
                        wrap       = (m_count[i] == MAXV);
                        m_count[i] = (m_count[i] + 1) % (MAXV + 1);
                    end else begin
                        wrap       = (m_count[i] == 0);
                        m_count[i] = (m_count[i] + MAXV) % (MAXV + 1);
                    end
                end
            end
            m_tc[i]    = wrap;
            m_ovf[i]   = wrap ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf[i]);
            m_match[i] = (m_count[i] == int'(cmp_val));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (count_a !== 4'd0) begin n_fail++; $display("FAIL reset_count_a got %0d exp 0", count_a); end
        n_checks++; if (count_b !== 4'd0) begin n_fail++; $display("FAIL reset_count_b got %0d exp 0", count_b); end
        n_checks++; if (tc_a !== 1'b0)    begin n_fail++; $display("FAIL reset_tc_a got %b exp 0", tc_a); end
        n_checks++; if (ovf_a !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf_a got %b exp 0", ovf_a); end
        n_checks++; if (ovf_b !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf_b got %b exp 0", ovf_b); end
`ifdef COUNTER_CMP_EN
        n_checks++; if (match_a !== 1'b0) begin n_fail++; $display("FAIL reset_match_a got %b exp 0", match_a); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_count_up();
        clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++; if (count_a !== W'(k % 10)) begin n_fail++; $display("FAIL up_count_a cyc %0d got %0d exp %0d", k, count_a, k % 10); end
            n_checks++; if (tc_a !== (k == 10))      begin n_fail++; $display("FAIL up_tc_a cyc %0d got %b exp %b", k, tc_a, (k == 10)); end
            n_checks++; if (ovf_a !== (k >= 10))     begin n_fail++; $display("FAIL up_ovf_a cyc %0d got %b exp %b", k, ovf_a, (k >= 10)); end
            n_checks++; if (count_b !== W'(m_count[1])) begin n_fail++; $display("FAIL up_count_b cyc %0d got %0d exp %0d", k, count_b, m_count[1]); end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap_down();
        clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; up = 1'b0;
        tick();
        en = 1'b0;
        n_checks++; if (count_a !== 4'd9) begin n_fail++; $display("FAIL down_wrap_count got %0d exp 9", count_a); end
        n_checks++; if (tc_a !== 1'b1)    begin n_fail++; $display("FAIL down_wrap_tc got %b exp 1", tc_a); end
        n_checks++; if (ovf_a !== 1'b1)   begin n_fail++; $display("FAIL down_wrap_ovf got %b exp 1", ovf_a); end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        n_checks++; if (ovf_a !== 1'b0)   begin n_fail++; $display("FAIL ovf_clr got %b exp 0", ovf_a); end
        n_checks++; if (tc_a !== 1'b0)    begin n_fail++; $display("FAIL tc_after_wrap got %b exp 0", tc_a); end
        n_checks++; if (count_a !== 4'd9) begin n_fail++; $display("FAIL hold_count got %0d exp 9", count_a); end
        clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; up = 1'b0; ovf_clr = 1'b1;
        tick();
        en = 1'b0; ovf_clr = 1'b0;
        n_checks++; if (ovf_a !== 1'b1)   begin n_fail++; $display("FAIL wrap_beats_ovf_clr got %b exp 1", ovf_a); end
    endtask

    task automatic test_prescale();
        bit en_pat [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        int exp_b  [11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};
        clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_checks++; if (count_b !== W'(k / 3)) begin n_fail++; $display("FAIL presc_count_b cyc %0d got %0d exp %0d", k, count_b, k / 3); end
        end
        clr = 1'b1; tick(); clr = 1'b0;
        for (int k = 0; k < 11; k++) begin
            en = en_pat[k];
            // Direction flips only on non-step cycles; steps must still go up.
            up = (k == 4 || k == 6) ? 1'b0 : 1'b1;
            tick();
            n_checks++; if (count_b !== W'(exp_b[k])) begin n_fail++; $display("FAIL presc_gap_count_b cyc %0d got %0d exp %0d", k + 1, count_b, exp_b[k]); end
        end
        en = 1'b0; up = 1'b1;
    endtask

    task automatic test_priority();
        load = 1'b1; load_val = 4'd3; tick();
        clr = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1; up = 1'b1;
        tick();
        n_checks++; if (count_a !== 4'd0) begin n_fail++; $display("FAIL clr_wins_a got %0d exp 0", count_a); end
        n_checks++; if (count_b !== 4'd0) begin n_fail++; $display("FAIL clr_wins_b got %0d exp 0", count_b); end
        n_checks++; if (tc_a !== 1'b0)    begin n_fail++; $display("FAIL clr_tc got %b exp 0", tc_a); end
        clr = 1'b0; load = 1'b1; load_val = 4'd15;
        tick();
        n_checks++; if (count_a !== 4'd9) begin n_fail++; $display("FAIL load_clamp_a got %0d exp 9", count_a); end
        n_checks++; if (count_b !== 4'd9) begin n_fail++; $display("FAIL load_clamp_b got %0d exp 9", count_b); end
        n_checks++; if (tc_a !== 1'b0)    begin n_fail++; $display("FAIL load_tc got %b exp 0", tc_a); end
        load_val = 4'd9;
        tick();
        n_checks++; if (count_a !== 4'd9) begin n_fail++; $display("FAIL load_over_step got %0d exp 9", count_a); end
        n_checks++; if (tc_a !== 1'b0)    begin n_fail++; $display("FAIL load_over_step_tc got %b exp 0", tc_a); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_async_reset();
        clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; up = 1'b0; tick(); en = 1'b0;
        load = 1'b1; load_val = 4'd5; tick(); load = 1'b0;
        en = 1'b1; up = 1'b1; tick(); tick(); en = 1'b0;
        n_checks++; if (count_a !== 4'd7) begin n_fail++; $display("FAIL pre_rst_count_a got %0d exp 7", count_a); end
        n_checks++; if (count_b !== 4'd5) begin n_fail++; $display("FAIL pre_rst_count_b got %0d exp 5", count_b); end
        n_checks++; if (ovf_a !== 1'b1)   begin n_fail++; $display("FAIL pre_rst_ovf_a got %b exp 1", ovf_a); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (count_a !== 4'd0) begin n_fail++; $display("FAIL async_rst_count_a got %0d exp 0", count_a); end
        n_checks++; if (count_b !== 4'd0) begin n_fail++; $display("FAIL async_rst_count_b got %0d exp 0", count_b); end
        n_checks++; if (ovf_a !== 1'b0)   begin n_fail++; $display("FAIL async_rst_ovf_a got %b exp 0", ovf_a); end
        model_reset();
        #1 rst = 1'b0;
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++; if (count_a !== W'(k))       begin n_fail++; $display("FAIL post_rst_count_a cyc %0d got %0d exp %0d", k, count_a, k); end
            n_checks++; if (count_b !== W'(k == 3))  begin n_fail++; $display("FAIL post_rst_count_b cyc %0d got %0d exp %0d", k, count_b, (k == 3)); end
        end
        en = 1'b0;
    endtask

`ifdef COUNTER_CMP_EN
    task automatic test_compare();
        cmp_val = 4'd4;
        clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++; if (match_a !== ((k % 10) == 4)) begin n_fail++; $display("FAIL match_a cyc %0d got %b exp %b", k, match_a, ((k % 10) == 4)); end
            n_checks++; if (match_b !== m_match[1])      begin n_fail++; $display("FAIL match_b cyc %0d got %b exp %b", k, match_b, m_match[1]); end
        end
        en = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            en       = ($urandom_range(0, 3) != 0);
            clr      = ($urandom_range(0, 31) == 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = W'($urandom);
            ovf_clr  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) up = ~up;
            if ($urandom_range(0, 15) == 0) cmp_val = W'($urandom_range(0, MAXV));
            tick();
            n_checks++; if (count_a !== W'(m_count[0])) begin n_fail++; $display("FAIL rnd_count_a cyc %0d got %0d exp %0d", k, count_a, m_count[0]); end
            n_checks++; if (count_b !== W'(m_count[1])) begin n_fail++; $display("FAIL rnd_count_b cyc %0d got %0d exp %0d", k, count_b, m_count[1]); end
            n_checks++; if (tc_a !== m_tc[0])   begin n_fail++; $display("FAIL rnd_tc_a cyc %0d got %b exp %b", k, tc_a, m_tc[0]); end
            n_checks++; if (tc_b !== m_tc[1])   begin n_fail++; $display("FAIL rnd_tc_b cyc %0d got %b exp %b", k, tc_b, m_tc[1]); end
            n_checks++; if (ovf_a !== m_ovf[0]) begin n_fail++; $display("FAIL rnd_ovf_a cyc %0d got %b exp %b", k, ovf_a, m_ovf[0]); end
            n_checks++; if (ovf_b !== m_ovf[1]) begin n_fail++; $display("FAIL rnd_ovf_b cyc %0d got %b exp %b", k, ovf_b, m_ovf[1]); end
`ifdef COUNTER_CMP_EN
            n_checks++; if (match_a !== m_match[0]) begin n_fail++; $display("FAIL rnd_match_a cyc %0d got %b exp %b", k, match_a, m_match[0]); end
            n_checks++; if (match_b !== m_match[1]) begin n_fail++; $display("FAIL rnd_match_b cyc %0d got %b exp %b", k, match_b, m_match[1]); end
`endif
            // Occasional mid-cycle reset pulse discards any partial prescale.
            if ($urandom_range(0, 79) == 0) begin
                #1 rst = 1'b1;
                model_reset();
                #1 rst = 1'b0;
            end
        end
        en = 1'b0; clr = 1'b0; load = 1'b0; ovf_clr = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        up       = 1'b1;
        ovf_clr  = 1'b0;
        load_val = '0;
        cmp_val  = '0;
        test_reset();
        test_count_up();
        test_wrap_down();
        test_prescale();
        test_priority();
        test_async_reset();
`ifdef COUNTER_CMP_EN
        test_compare();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
